// File: rtl/frame_arbiter.sv
// Four-port round-robin frame arbiter: forwards whole AXI-Stream frames from one
// granted source to a single egress, with an Avalon-MM register block for control.
module frame_arbiter #(
    parameter logic [3:0] DEFAULT_ENABLE = 4'hF,
    parameter logic [7:0] DEFAULT_GAP    = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    input  logic [63:0] in_tdata,
    input  logic [3:0]  in_tvalid,
    output logic [3:0]  in_tready,
    input  logic [3:0]  in_tlast,
    output logic [15:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_grant_q;
    logic [7:0]  gap_cnt_q;
    logic [3:0]  enable_q;
    logic [7:0]  gap_q;
    logic [7:0]  cnt_q [4];
    logic [7:0]  readdata_q;
    logic [7:0]  readdata_d;

    logic [3:0]  cand;
    logic [1:0]  pick;
    logic        pick_valid;
    logic        pass;
    logic        beat_last;
    logic        bus_wr;
    logic        bus_rd;
    logic        cnt_clr;

    assign bus_wr  = chipselect && write;
    assign bus_rd  = chipselect && read;
    assign cnt_clr = bus_wr && (address == 8'd7);
    assign cand    = in_tvalid & enable_q;

    // First candidate strictly after last_grant, wrapping back to last_grant itself.
    always_comb begin
        logic [1:0] idx;
        pick_valid = 1'b0;
        pick       = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant_q + 2'(i);
            if (!pick_valid && cand[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Handshake: a beat moves on any edge where out_tvalid && out_tready; the granted
    // source sees out_tready as its in_tready, so data and valid pass straight through.
    assign pass       = (state_q == S_PASS);
    assign out_tdata  = pass ? in_tdata[{grant_q, 4'b0000} +: 16] : 16'h0000;
    assign out_tvalid = pass && in_tvalid[grant_q];
    assign out_tlast  = pass && in_tlast[grant_q];
    assign in_tready  = pass ? ({3'b000, out_tready} << grant_q) : 4'h0;
    assign beat_last  = out_tvalid && out_tready && out_tlast;
    assign dbg_state  = state_q;
    assign readdata   = readdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            gap_cnt_q    <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick;
                        state_q <= S_PASS;
                    end
                end
                S_PASS: begin
                    if (beat_last) begin
                        last_grant_q <= grant_q;
                        if (gap_q != 8'd0) begin
                            gap_cnt_q <= gap_q;
                            state_q   <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q <= 8'd1) state_q <= S_IDLE;
                    else                   gap_cnt_q <= gap_cnt_q - 8'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        readdata_d = 8'h00;
        if (bus_rd) begin
            case (address)
                8'd0:    readdata_d = {4'h0, enable_q};
                8'd1:    readdata_d = gap_q;
                8'd2:    readdata_d = {(state_q != S_IDLE), 5'b00000, grant_q};
                8'd3:    readdata_d = cnt_q[0];
                8'd4:    readdata_d = cnt_q[1];
                8'd5:    readdata_d = cnt_q[2];
                8'd6:    readdata_d = cnt_q[3];
                default: readdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q   <= DEFAULT_ENABLE;
            gap_q      <= DEFAULT_GAP;
            readdata_q <= 8'h00;
            for (int p = 0; p < 4; p++) cnt_q[p] <= 8'h00;
        end else begin
            readdata_q <= readdata_d;
            if (bus_wr && address == 8'd0) enable_q <= writedata[3:0];
            if (bus_wr && address == 8'd1) gap_q    <= writedata;
            // A clear coinciding with a frame end wins over the increment.
            for (int p = 0; p < 4; p++) begin
                if (cnt_clr)
                    cnt_q[p] <= 8'h00;
                else if (beat_last && grant_q == 2'(p))
                    cnt_q[p] <= cnt_q[p] + 8'd1;
            end
        end
    end
endmodule
